// File: rtl/fifo_pkg.sv
// Shared definitions for the stream FIFO reader: occupancy state encoding
// and the width of the overflow event counter.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_e;

  localparam int OVF_CNT_W = 8;

endpackage

// File: rtl/fifo_ptr.sv
// Circular FIFO pointer: advances by one on inc and wraps naturally at DEPTH,
// which is a power of two, so the wrap is free.
module fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge value of its neighbours regardless of process order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/stream_fifo_reader.sv
// Show-ahead stream FIFO: dout always presents the oldest entry, and a write
// into a full FIFO discards the oldest entry and reports an overflow.
module stream_fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     wr,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [OVF_CNT_W-1:0]     ovf_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  overflow_q;
  logic [OVF_CNT_W-1:0]  ovf_cnt_q;

  occ_state_e state_q;
  occ_state_e state_d;

  logic push;
  logic pop;
  logic rd_inc;
  logic cnt_up;
  logic cnt_dn;
  logic ovf_event;

  // Flags come from the occupancy count alone; pointers are equal both when
  // empty and when full, so they cannot tell the two apart.
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign dout_valid = !empty;
  assign dout       = mem[rd_ptr];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign ovf_cnt    = ovf_cnt_q;

  assign push = wr;
  assign pop  = dout_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (push) state_d = PARTIAL;
      PARTIAL: begin
        if (cnt_up && count_q == CNT_W'(DEPTH - 1)) begin
          state_d = FULL;
        end else if (cnt_dn && count_q == CNT_W'(1)) begin
          state_d = EMPTY;
        end
      end
      FULL:    if (cnt_dn) state_d = PARTIAL;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    rd_inc    = pop;
    cnt_up    = 1'b0;
    cnt_dn    = 1'b0;
    ovf_event = 1'b0;
    unique case (state_q)
      EMPTY: begin
        cnt_up = push;
      end
      PARTIAL: begin
        cnt_up = push && !pop;
        cnt_dn = pop && !push;
      end
      FULL: begin
        // A write with no read overwrites the oldest entry, so the read
        // pointer must step past it.
        cnt_dn    = pop && !push;
        ovf_event = push && !pop;
        rd_inc    = pop || push;
      end
      default: begin
        rd_inc = 1'b0;
      end
    endcase
  end

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (push),
    .ptr    (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (rd_inc),
    .ptr    (rd_ptr)
  );

  // NOTE: storage is cleared on reset so dout reads 0 afterwards; this keeps
  // the array in flops rather than a RAM macro, which suits a small FIFO.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      if (cnt_up) begin
        count_q <= count_q + 1'b1;
      end else if (cnt_dn) begin
        count_q <= count_q - 1'b1;
      end
      overflow_q <= ovf_event;
      if (ovf_event && ovf_cnt_q != '1) begin
        ovf_cnt_q <= ovf_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_fifo_reader.sv
// Directed bench for stream_fifo_reader (DATA_WIDTH=8, DEPTH=4): each task
// drives one scenario and compares outputs against hand-derived values.
module tb_stream_fifo_reader;

  logic       clk;
  logic       resetn;
  logic [7:0] din;
  logic       wr;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] ovf_cnt;

  int checks = 0;
  int passed = 0;

  stream_fifo_reader #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .wr         (wr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .ovf_cnt    (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset_values(input string tag);
    checks++; if (dout !== 8'h00) $display("FAIL %s dout: got %h want 00", tag, dout); else passed++;
    checks++; if (dout_valid !== 1'b0) $display("FAIL %s dout_valid: got %b want 0", tag, dout_valid); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL %s empty: got %b want 1", tag, empty); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL %s full: got %b want 0", tag, full); else passed++;
    checks++; if (count !== 3'd0) $display("FAIL %s count: got %0d want 0", tag, count); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL %s overflow: got %b want 0", tag, overflow); else passed++;
    checks++; if (ovf_cnt !== 8'd0) $display("FAIL %s ovf_cnt: got %0d want 0", tag, ovf_cnt); else passed++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; wr = 1'b0; din = 8'h00; dout_ready = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    expect_reset_values("reset");
  endtask

  task automatic test_write_read();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; din = vals[i];
      if (i == 0) begin
        checks++; if (dout_valid !== 1'b0) $display("FAIL no_bypass valid: got %b want 0", dout_valid); else passed++;
      end
      tick();
    end
    wr = 1'b0;
    checks++; if (count !== 3'd3) $display("FAIL wr3 count: got %0d want 3", count); else passed++;
    checks++; if (dout !== 8'h11) $display("FAIL wr3 dout: got %h want 11", dout); else passed++;
    checks++; if (dout_valid !== 1'b1) $display("FAIL wr3 dout_valid: got %b want 1", dout_valid); else passed++;
    checks++; if (empty !== 1'b0) $display("FAIL wr3 empty: got %b want 0", empty); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL wr3 full: got %b want 0", full); else passed++;
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dout !== vals[i]) $display("FAIL rd%0d dout: got %h want %h", i, dout, vals[i]); else passed++;
      tick();
    end
    dout_ready = 1'b0;
    checks++; if (empty !== 1'b1) $display("FAIL drain empty: got %b want 1", empty); else passed++;
    checks++; if (count !== 3'd0) $display("FAIL drain count: got %0d want 0", count); else passed++;
    checks++; if (dout_valid !== 1'b0) $display("FAIL drain dout_valid: got %b want 0", dout_valid); else passed++;
    // Ready while empty must not move anything.
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
    checks++; if (count !== 3'd0) $display("FAIL idle_ready count: got %0d want 0", count); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; din = 8'hA0 + 8'(i); tick();
    end
    checks++; if (full !== 1'b1) $display("FAIL fill full: got %b want 1", full); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL fill overflow: got %b want 0", overflow); else passed++;
    din = 8'hA4; tick();
    wr = 1'b0;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf pulse: got %b want 1", overflow); else passed++;
    checks++; if (ovf_cnt !== 8'd1) $display("FAIL ovf ovf_cnt: got %0d want 1", ovf_cnt); else passed++;
    checks++; if (dout !== 8'hA1) $display("FAIL ovf dout: got %h want a1", dout); else passed++;
    checks++; if (count !== 3'd4) $display("FAIL ovf count: got %0d want 4", count); else passed++;
    tick();
    checks++; if (overflow !== 1'b0) $display("FAIL ovf pulse_end: got %b want 0", overflow); else passed++;
    checks++; if (ovf_cnt !== 8'd1) $display("FAIL ovf ovf_cnt_hold: got %0d want 1", ovf_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_dout [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB0, 8'hB1};
    wr = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 8'hB0 + 8'(i);
      checks++; if (dout !== exp_dout[i]) $display("FAIL b2b%0d dout: got %h want %h", i, dout, exp_dout[i]); else passed++;
      tick();
      checks++; if (count !== 3'd4) $display("FAIL b2b%0d count: got %0d want 4", i, count); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL b2b%0d overflow: got %b want 0", i, overflow); else passed++;
    end
    wr = 1'b0; dout_ready = 1'b0;
    checks++; if (dout !== 8'hB2) $display("FAIL b2b_end dout: got %h want b2", dout); else passed++;
    checks++; if (ovf_cnt !== 8'd1) $display("FAIL b2b_end ovf_cnt: got %0d want 1", ovf_cnt); else passed++;
  endtask

  task automatic test_empty_write_read();
    dout_ready = 1'b1;
    repeat (4) tick();
    checks++; if (empty !== 1'b1) $display("FAIL pre_pass empty: got %b want 1", empty); else passed++;
    wr = 1'b1; din = 8'h5A;
    #1;
    checks++; if (dout_valid !== 1'b0) $display("FAIL pass same_cycle valid: got %b want 0", dout_valid); else passed++;
    tick();
    wr = 1'b0; dout_ready = 1'b0;
    checks++; if (dout !== 8'h5A) $display("FAIL pass dout: got %h want 5a", dout); else passed++;
    checks++; if (dout_valid !== 1'b1) $display("FAIL pass dout_valid: got %b want 1", dout_valid); else passed++;
    checks++; if (count !== 3'd1) $display("FAIL pass count: got %0d want 1", count); else passed++;
  endtask

  task automatic test_reset_mid();
    wr = 1'b1; din = 8'h61; tick();
    din = 8'h62; tick();
    checks++; if (count !== 3'd3) $display("FAIL pre_rst count: got %0d want 3", count); else passed++;
    resetn = 1'b0; wr = 1'b1; din = 8'h77; dout_ready = 1'b1;
    tick();
    resetn = 1'b1; wr = 1'b0; dout_ready = 1'b0;
    expect_reset_values("mid_reset");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; din = 8'(i); tick();
    end
    for (int i = 0; i < 300; i++) begin
      din = 8'(i + 4); tick();
      if (i == 253) begin
        checks++; if (ovf_cnt !== 8'd254) $display("FAIL sat254 ovf_cnt: got %0d want 254", ovf_cnt); else passed++;
      end
    end
    wr = 1'b0;
    checks++; if (ovf_cnt !== 8'd255) $display("FAIL sat ovf_cnt: got %0d want 255", ovf_cnt); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL sat overflow: got %b want 1", overflow); else passed++;
    checks++; if (count !== 3'd4) $display("FAIL sat count: got %0d want 4", count); else passed++;
    tick();
    checks++; if (overflow !== 1'b0) $display("FAIL sat overflow_end: got %b want 0", overflow); else passed++;
    checks++; if (ovf_cnt !== 8'd255) $display("FAIL sat ovf_cnt_hold: got %0d want 255", ovf_cnt); else passed++;
  endtask

  initial begin
    resetn = 1'b0; wr = 1'b0; din = 8'h00; dout_ready = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_overflow();
    test_back_to_back();
    test_empty_write_read();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/stream_fifo_reader.md
STREAM_FIFO_READER -- requirements
Module: stream_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port din  input  DATA_WIDTH  write data.
REQ-006 SHALL have port wr  input  1  write strobe; din is captured on every cycle wr=1.
REQ-007 SHALL have port dout  output  DATA_WIDTH  oldest entry (show-ahead).
REQ-008 SHALL have port dout_valid  output  1  dout holds a valid entry.
REQ-009 SHALL have port dout_ready  input  1  consumer accepts dout.
REQ-010 SHALL have port full  output  1  count equals DEPTH.
REQ-011 SHALL have port empty  output  1  count equals 0.
REQ-012 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port overflow  output  1  registered one-cycle pulse, oldest entry discarded.
REQ-014 SHALL have port ovf_cnt  output  8  saturating count of overflow events.

Function
REQ-015 SHALL drive dout combinationally from the entry at the read pointer; no output register.
REQ-016 SHALL drive dout_valid = !empty, full = (count==DEPTH), empty = (count==0).
REQ-017 SHALL define pop = dout_valid && dout_ready and push = wr.
REQ-018 Push only, not full: SHALL write din at the write pointer, advance it modulo DEPTH, count+1.
REQ-019 Pop only: SHALL advance the read pointer modulo DEPTH, count-1; the entry data is left in place.
REQ-020 Push and pop, count between 1 and DEPTH inclusive: SHALL perform both; count is unchanged; overflow is not asserted.
REQ-021 Push while empty: SHALL NOT bypass din to dout; the entry is visible on dout the next cycle.
REQ-022 Push while full, no pop: SHALL overwrite the oldest entry and advance both pointers; count stays DEPTH.
REQ-023 In that case SHALL assert overflow the following cycle for exactly one cycle per event.
REQ-024 In that case SHALL increment ovf_cnt, saturating at 255.
REQ-025 dout_ready while empty SHALL have no effect.
REQ-026 Pointers SHALL be clog2(DEPTH) bits wide and wrap naturally.
REQ-027 full and empty SHALL derive from count only, never from pointer comparison.
REQ-028 Occupancy state SHALL be EMPTY (count 0), PARTIAL (count 1 to DEPTH-1) or FULL (count DEPTH).
REQ-029 EMPTY SHALL move to PARTIAL on push; with DEPTH=2, PARTIAL SHALL move to FULL on push without pop.
REQ-030 FULL SHALL move to PARTIAL on pop without push.

Reset
REQ-031 While resetn=0 at a clock edge, SHALL clear all entries to 0, both pointers to 0, count to 0 and ovf_cnt to 0, and SHALL clear overflow.
REQ-032 Outputs after reset SHALL be dout=0, dout_valid=0, empty=1, full=0, count=0, overflow=0, ovf_cnt=0.
REQ-033 Reset asserted mid-operation SHALL take priority over a simultaneous push or pop; the push and pop are ignored.

Structure
REQ-034 Shared package fifo_pkg SHALL hold the occupancy state enum (EMPTY/PARTIAL/FULL) and the ovf_cnt width constant (8).
REQ-035 Pointer increment-with-wrap SHALL be a sub-module fifo_ptr (parameter DEPTH; inputs clk, resetn, inc; output ptr), instantiated twice.

Verification
REQ-036 Reset, then write 0x11, 0x22, 0x33 with dout_ready=0 -> count=3, dout=0x11, dout_valid=1, empty=0, full=0.
REQ-037 From that state, dout_ready=1 for 3 cycles -> dout sequence 0x11, 0x22, 0x33, then empty=1, count=0.
REQ-038 Fill with 0xA0..0xA3, then write 0xA4 with dout_ready=0 -> overflow high for one cycle, ovf_cnt=1, dout=0xA1, count=4.
REQ-039 Full FIFO, wr=1 and dout_ready=1 for 6 cycles with data 0xB0..0xB5 -> count stays 4, overflow stays 0, dout order preserved across pointer wrap.
REQ-040 Empty FIFO, wr=1 with din=0x5A and dout_ready=1 -> dout_valid=0 that cycle, dout=0x5A and dout_valid=1 next cycle.
REQ-041 Hold resetn=0 for one cycle while count=3 and wr=1 -> next cycle all outputs at reset values; 300 overflow events -> ovf_cnt=255.
